// File: rtl/ov_cam_pkg.sv
// Shared types and helpers for the OV7670-class DVP capture front end.
// Holds the capture FSM encoding, geometry helpers and the grey-to-RGB565 expansion.
package ov_cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FRAME      = 2'd1,
    ST_DONE       = 2'd2,
    ST_WAIT_START = 2'd3
  } cap_state_e;

  localparam int DEF_IMG_W      = 320;
  localparam int DEF_IMG_H      = 240;
  localparam int BYTES_PER_LINE = 2 * DEF_IMG_W;

  function automatic int bytes_per_line(input int img_w);
    return 2 * img_w;
  endfunction

  // A one-pixel buffer still needs a 1-bit address port.
  function automatic int addr_width(input int img_w, input int img_h);
    return (img_w * img_h > 1) ? $clog2(img_w * img_h) : 1;
  endfunction

  function automatic logic [15:0] grey_to_rgb565(input logic [7:0] y);
    return {y[7:3], y[7:2], y[7:3]};
  endfunction

endpackage

// File: rtl/ov_sync_pipe.sv
// Two-stage alignment register for the camera pins {href, vsync, data}.
// All bits share the same delay so data stays lined up with its qualifiers.
module ov_sync_pipe
  import ov_cam_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         ov_pclk,
  input  logic         rstn,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage1_q, stage1_d;
  logic [W-1:0] stage2_q, stage2_d;

  always_comb begin
    stage1_d = din;
    stage2_d = stage1_q;
  end

  always_ff @(posedge ov_pclk or negedge rstn) begin
    if (!rstn) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign dout = stage2_q;

endmodule

// File: rtl/ov_capture_ctrl.sv
// DVP camera capture controller: turns the 8-bit byte stream into 16-bit frame buffer writes
// at row_base + col, with format select, byte swap, clipping and frame/line error reporting.
module ov_capture_ctrl
  import ov_cam_pkg::*;
#(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int FCNT_W = 8,
  localparam int AW    = addr_width(IMG_W, IMG_H)
) (
  input  logic              ov_pclk,
  input  logic              rstn,
  input  logic              cap_en,
  input  logic              fmt_grey,
  input  logic              swap_bytes,
  input  logic              href,
  input  logic              vsync,
  input  logic [7:0]        ov7670_data,
  output logic              WE,
  output logic [AW-1:0]     wAddr,
  output logic [15:0]       wData,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              line_err,
  output logic              frame_err
);

  localparam int BPL = bytes_per_line(IMG_W);
  // Byte counter spans two full lines so overlong lines never alias to a correct count.
  localparam int BCW = $clog2(2 * BPL + 1);
  localparam int CW  = $clog2(IMG_W + 1);
  localparam int LCW = $clog2(IMG_H + 2);

  logic [9:0] sync_out;
  logic       h2, v2;
  logic [7:0] d2;

  ov_sync_pipe #(.W(10)) u_sync (
    .ov_pclk (ov_pclk),
    .rstn    (rstn),
    .din     ({href, vsync, ov7670_data}),
    .dout    (sync_out)
  );

  assign h2 = sync_out[9];
  assign v2 = sync_out[8];
  assign d2 = sync_out[7:0];

  cap_state_e        state_q, state_d;
  logic              h2_prev_q, h2_prev_d;
  logic              v2_prev_q, v2_prev_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]     col_q, col_d;
  logic [LCW-1:0]    line_cnt_q, line_cnt_d;
  logic [AW-1:0]     row_base_q, row_base_d;
  logic [7:0]        hold_q, hold_d;
  logic              grey_q, grey_d;
  logic              swap_q, swap_d;
  logic              line_err_q, line_err_d;
  logic              frame_err_q, frame_err_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              we_q, we_d;
  logic [AW-1:0]     waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;

  logic v_fall, v_rise, h_fall, frame_start, line_abort;
  logic [15:0] pixel;

  assign v_fall      = v2_prev_q & ~v2;
  assign v_rise      = ~v2_prev_q & v2;
  assign h_fall      = h2_prev_q & ~h2;
  assign frame_start = ((state_q == ST_IDLE) || (state_q == ST_WAIT_START)) && v_fall && cap_en;
  assign line_abort  = v_rise && h2;

  always_ff @(posedge ov_pclk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_WAIT_START: if (v_fall && cap_en) state_d = ST_FRAME;
      ST_FRAME:               if (v_rise) state_d = ST_DONE;
      ST_DONE:                state_d = cap_en ? ST_WAIT_START : ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      ST_IDLE:  busy = 1'b0;
      ST_DONE:  begin busy = 1'b1; frame_done = 1'b1; end
      default:  busy = 1'b1;
    endcase
  end

  always_comb begin
    if (grey_q)      pixel = grey_to_rgb565(hold_q);
    else if (swap_q) pixel = {d2, hold_q};
    else             pixel = {hold_q, d2};
  end

  always_comb begin
    h2_prev_d   = h2;
    v2_prev_d   = v2;
    byte_cnt_d  = byte_cnt_q;
    col_d       = col_q;
    line_cnt_d  = line_cnt_q;
    row_base_d  = row_base_q;
    hold_d      = hold_q;
    grey_d      = grey_q;
    swap_d      = swap_q;
    line_err_d  = line_err_q;
    frame_err_d = frame_err_q;
    frame_cnt_d = frame_cnt_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;

    if (frame_start) begin
      line_err_d  = 1'b0;
      frame_err_d = 1'b0;
      line_cnt_d  = '0;
      row_base_d  = '0;
      col_d       = '0;
      byte_cnt_d  = '0;
      grey_d      = fmt_grey;
      swap_d      = swap_bytes;
    end

    if (state_q == ST_FRAME) begin
      // A vsync rise mid-line ends that line early; the partial byte is dropped.
      if (h_fall || line_abort) begin
        if (line_abort || (byte_cnt_q != BCW'(BPL))) line_err_d = 1'b1;
        if (line_cnt_q != LCW'(IMG_H + 1)) line_cnt_d = line_cnt_q + LCW'(1);
        if (line_cnt_q < LCW'(IMG_H - 1)) row_base_d = row_base_q + AW'(IMG_W);
        col_d      = '0;
        byte_cnt_d = '0;
      end else if (h2) begin
        if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + BCW'(1);
        if (!byte_cnt_q[0]) begin
          hold_d = d2;
        end else if ((col_q < CW'(IMG_W)) && (line_cnt_q < LCW'(IMG_H))) begin
          we_d    = 1'b1;
          waddr_d = row_base_q + AW'(col_q);
          wdata_d = pixel;
          col_d   = col_q + CW'(1);
        end
      end
    end

    if (state_q == ST_DONE) begin
      frame_cnt_d = frame_cnt_q + FCNT_W'(1);
      if (line_cnt_q != LCW'(IMG_H)) frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge ov_pclk or negedge rstn) begin
    if (!rstn) begin
      h2_prev_q   <= 1'b0;
      v2_prev_q   <= 1'b0;
      byte_cnt_q  <= '0;
      col_q       <= '0;
      line_cnt_q  <= '0;
      row_base_q  <= '0;
      hold_q      <= '0;
      grey_q      <= 1'b0;
      swap_q      <= 1'b0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      h2_prev_q   <= h2_prev_d;
      v2_prev_q   <= v2_prev_d;
      byte_cnt_q  <= byte_cnt_d;
      col_q       <= col_d;
      line_cnt_q  <= line_cnt_d;
      row_base_q  <= row_base_d;
      hold_q      <= hold_d;
      grey_q      <= grey_d;
      swap_q      <= swap_d;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign WE        = we_q;
  assign wAddr     = waddr_q;
  assign wData     = wdata_q;
  assign frame_cnt = frame_cnt_q;
  assign line_err  = line_err_q;
  assign frame_err = frame_err_q;

endmodule
